// File: rtl/xpb_seq_pkg.sv
// Shared defaults and FSM state type for the xpb reduction sequencer.
package xpb_seq_pkg;

  localparam int XPB_DIGIT_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } xpb_state_e;

endpackage

// File: rtl/xpb_seq_ctrl.sv
// Sequencer control: job FSM, digit counter, registered table-issue outputs and
// issue-valid pipe. XPB_ZERO_SKIP_EN suppresses lookups for zero digits.
module xpb_seq_ctrl
  import xpb_seq_pkg::*;
#(
  parameter int DIGIT_BITS  = XPB_DIGIT_BITS,
  parameter int NUM_DIGITS  = 8,
  parameter int LUT_LATENCY = 1,
  localparam int SEL_BITS   = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_out_ready,
  output logic                  o_out_valid,
  input  logic [DIGIT_BITS-1:0] i_issue_digit,
  output logic [SEL_BITS-1:0]   o_issue_idx,
  output logic                  o_load,
  output logic                  o_add_vld,
  output logic                  o_lut_en,
  output logic [SEL_BITS-1:0]   o_lut_sel,
  output logic [DIGIT_BITS-1:0] o_lut_digit
);

  localparam int DRN_BITS = $clog2(LUT_LATENCY + 1);
  localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(NUM_DIGITS - 1);
  localparam logic [DRN_BITS-1:0] DRN_INIT = DRN_BITS'(LUT_LATENCY - 1);

  xpb_state_e             r_state, w_state_nxt;
  logic [SEL_BITS-1:0]    r_cnt, w_cnt_nxt;
  logic [DRN_BITS-1:0]    r_drn, w_drn_nxt;
  logic [LUT_LATENCY-1:0] r_pipe, w_pipe_nxt;
  logic                   w_issue;
  logic                   w_load;
  logic                   w_en;
  logic [SEL_BITS-1:0]    w_issue_idx;
  logic                   r_lut_en;
  logic [SEL_BITS-1:0]    r_lut_sel;
  logic [DIGIT_BITS-1:0]  r_lut_digit;
  logic                   r_out_valid;

  // State, digit counter and drain countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drn   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drn   <= w_drn_nxt;
    end
  end

  // Next state; w_issue marks a digit slot presented to the table next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drn_nxt   = r_drn;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_issue_idx = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_load      = 1'b1;
          w_issue     = 1'b1;
          w_issue_idx = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == LAST_IDX) begin
          w_drn_nxt   = DRN_INIT;
          w_state_nxt = DRAIN;
        end else begin
          w_issue     = 1'b1;
          w_cnt_nxt   = r_cnt + SEL_BITS'(1);
          w_issue_idx = r_cnt + SEL_BITS'(1);
        end
      end
      // The last lookup returns LUT_LATENCY cycles after it issued; counting
      // slots rather than set bits keeps latency fixed when zeros are skipped.
      DRAIN: begin
        if (r_drn == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_drn_nxt = r_drn - DRN_BITS'(1);
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef XPB_ZERO_SKIP_EN
  assign w_en = w_issue && (i_issue_digit != '0);
`else
  assign w_en = w_issue;
`endif

  // Shift the issued-enable into the issue-valid pipe
  always_comb begin
    w_pipe_nxt    = '0;
    w_pipe_nxt[0] = r_lut_en;
    for (int i = 1; i < LUT_LATENCY; i++) begin
      w_pipe_nxt[i] = r_pipe[i-1];
    end
  end

  // Registered table-issue and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lut_en    <= 1'b0;
      r_lut_sel   <= '0;
      r_lut_digit <= '0;
      r_pipe      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_lut_en <= w_en;
      if (w_en) begin
        r_lut_sel   <= w_issue_idx;
        r_lut_digit <= i_issue_digit;
      end
      r_pipe      <= w_pipe_nxt;
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  assign o_in_ready  = (r_state == IDLE) && !rst;
  assign o_out_valid = r_out_valid;
  assign o_issue_idx = w_issue_idx;
  assign o_load      = w_load;
  assign o_add_vld   = r_pipe[LUT_LATENCY-1];
  assign o_lut_en    = r_lut_en;
  assign o_lut_sel   = r_lut_sel;
  assign o_lut_digit = r_lut_digit;

endmodule

// File: rtl/xpb_reduce_seq.sv
// Walks product upper digits through one shared xpb table bank and sums the
// returned words. XPB_ZERO_SKIP_EN skips lookups for zero digits.
module xpb_reduce_seq
  import xpb_seq_pkg::*;
#(
  parameter int DIGIT_BITS  = XPB_DIGIT_BITS,
  parameter int NUM_DIGITS  = 8,
  parameter int WORD_BITS   = 1024,
  parameter int LUT_LATENCY = 1,
  localparam int SEL_BITS   = $clog2(NUM_DIGITS),
  localparam int ACC_BITS   = WORD_BITS + $clog2(NUM_DIGITS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] in_digits,
  output logic                             lut_en,
  output logic [SEL_BITS-1:0]              lut_sel,
  output logic [DIGIT_BITS-1:0]            lut_digit,
  input  logic [WORD_BITS-1:0]             lut_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_BITS-1:0]              out_sum
);

  logic [NUM_DIGITS*DIGIT_BITS-1:0] r_digits;
  logic [ACC_BITS-1:0]              r_acc;
  logic [DIGIT_BITS-1:0]            w_issue_digit;
  logic [SEL_BITS-1:0]              w_issue_idx;
  logic                             w_load;
  logic                             w_add_vld;

  xpb_seq_ctrl #(
    .DIGIT_BITS  (DIGIT_BITS),
    .NUM_DIGITS  (NUM_DIGITS),
    .LUT_LATENCY (LUT_LATENCY)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_out_ready   (out_ready),
    .o_out_valid   (out_valid),
    .i_issue_digit (w_issue_digit),
    .o_issue_idx   (w_issue_idx),
    .o_load        (w_load),
    .o_add_vld     (w_add_vld),
    .o_lut_en      (lut_en),
    .o_lut_sel     (lut_sel),
    .o_lut_digit   (lut_digit)
  );

  // Digit 0 issues on the accept edge, before the latch holds the job
  always_comb begin
    if (w_load) begin
      w_issue_digit = in_digits[DIGIT_BITS-1:0];
    end else begin
      w_issue_digit = r_digits[w_issue_idx*DIGIT_BITS +: DIGIT_BITS];
    end
  end

  // Job digit latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
    end else if (w_load) begin
      r_digits <= in_digits;
    end
  end

  // Full-width reduction accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_load) begin
      r_acc <= '0;
    end else if (w_add_vld) begin
      r_acc <= r_acc + ACC_BITS'(lut_data);
    end
  end

  assign out_sum = r_acc;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Scoreboarded random bench for xpb_reduce_seq at LUT_LATENCY 1 and 3.
module tb_xpb_reduce_seq;

  localparam int DB = 5;
  localparam int ND = 8;
  localparam int WB = 1024;
  localparam int AB = 1027;
`ifdef XPB_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk, rst;
  logic a_in_valid, a_in_ready, a_lut_en, a_out_valid, a_out_ready;
  logic b_in_valid, b_in_ready, b_lut_en, b_out_valid, b_out_ready;
  logic [2:0] a_lut_sel, b_lut_sel;
  logic [DB-1:0] a_lut_digit, b_lut_digit;
  logic [ND*DB-1:0] a_in_digits, b_in_digits;
  logic [WB-1:0] a_lut_data, b_lut_data, b_p1, b_p2;
  logic [AB-1:0] a_out_sum, b_out_sum;

  int n_checks = 0;
  int n_pass = 0;
  logic [AB-1:0] exp_q[$];
  bit use_b = 1'b0;
  bit stub_max = 1'b0;

  logic m_in_ready, m_lut_en, m_out_valid;
  logic [2:0] m_lut_sel;
  logic [DB-1:0] m_lut_digit;
  assign m_in_ready  = use_b ? b_in_ready  : a_in_ready;
  assign m_lut_en    = use_b ? b_lut_en    : a_lut_en;
  assign m_out_valid = use_b ? b_out_valid : a_out_valid;
  assign m_lut_sel   = use_b ? b_lut_sel   : a_lut_sel;
  assign m_lut_digit = use_b ? b_lut_digit : a_lut_digit;

  xpb_reduce_seq #(.LUT_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_digits(a_in_digits), .lut_en(a_lut_en), .lut_sel(a_lut_sel),
    .lut_digit(a_lut_digit), .lut_data(a_lut_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_sum(a_out_sum)
  );

  xpb_reduce_seq #(.LUT_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_digits(b_in_digits), .lut_en(b_lut_en), .lut_sel(b_lut_sel),
    .lut_digit(b_lut_digit), .lut_data(b_lut_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WB-1:0] junk();
    logic [WB-1:0] r;
    for (int i = 0; i < WB / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [WB-1:0] stub_word(input logic [2:0] sel, input logic [DB-1:0] dg);
    if (stub_max) return '1;
    return WB'((32'(sel) + 32'd1) * 32'(dg));
  endfunction

  // Table stubs: valid word LUT_LATENCY cycles after an enabled issue, noise otherwise
  always @(posedge clk) begin
    a_lut_data <= a_lut_en ? stub_word(a_lut_sel, a_lut_digit) : junk();
    b_p1       <= b_lut_en ? stub_word(b_lut_sel, b_lut_digit) : junk();
    b_p2       <= b_p1;
    b_lut_data <= b_p2;
  end

  // Reference: sum over digit positions of table(position, digit)
  function automatic logic [AB-1:0] model_sum(input logic [ND*DB-1:0] d, input bit mx);
    logic [AB-1:0] s;
    logic [AB-1:0] word_max;
    s = '0;
    word_max = '0;
    word_max[WB-1:0] = '1;
    for (int i = 0; i < ND; i++) begin
      if (mx) s = s + word_max;
      else    s = s + AB'((i + 1) * int'(d[i*DB +: DB]));
    end
    return s;
  endfunction

  function automatic logic [ND*DB-1:0] rand40(input bit zeros);
    logic [ND*DB-1:0] d;
    for (int i = 0; i < ND; i++) begin
      if (zeros && ($urandom_range(0, 2) == 0)) d[i*DB +: DB] = '0;
      else d[i*DB +: DB] = DB'($urandom());
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
                  act[AB-1:AB-64], act[127:0], exp[AB-1:AB-64], exp[127:0]);
  endtask

  task automatic drive(input logic v, input logic [ND*DB-1:0] d, input logic rdy);
    if (use_b) begin
      b_in_valid = v; b_in_digits = d; b_out_ready = rdy;
    end else begin
      a_in_valid = v; a_in_digits = d; a_out_ready = rdy;
    end
  endtask

  // Monitor: compare every presented sum against the scoreboard head
  always @(negedge clk) begin
    #2;
    if (!rst && (a_out_valid || b_out_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_sum", use_b ? b_out_sum : a_out_sum, exp_q[0]);
        if (use_b ? b_out_ready : a_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_job(input logic [ND*DB-1:0] d, input int hold, input bit mx);
    int lat, vcnt;
    bit seen, done, exp_en;
    logic [DB-1:0] dg;
    lat = use_b ? 3 : 1;
    stub_max = mx;
    @(negedge clk);
    check("in_ready_idle", m_in_ready, 1);
    exp_q.push_back(model_sum(d, mx));
    drive(1'b1, d, hold == 0);
    @(negedge clk);
    drive(1'b0, rand40(1'b0), hold == 0);
    vcnt = 0; seen = 0; done = 0;
    for (int cyc = 1; cyc < 40 && !done; cyc++) begin
      if (cyc <= ND) begin
        dg = d[(cyc-1)*DB +: DB];
        exp_en = SKIP ? (dg != '0) : 1'b1;
        check("lut_en", m_lut_en, exp_en);
        if (exp_en) begin
          check("lut_sel", m_lut_sel, cyc - 1);
          check("lut_digit", m_lut_digit, dg);
        end
      end else if (cyc == ND + 1) begin
        check("lut_en_off", m_lut_en, 0);
      end
      check("in_ready_busy", m_in_ready, 0);
      if (m_out_valid) begin
        vcnt++;
        if (!seen) check("out_valid_cycle", cyc, ND + lat + 1);
        seen = 1;
        if (vcnt > hold) begin
          drive(1'b0, rand40(1'b0), 1'b1);
          @(negedge clk);
          check("in_ready_after", m_in_ready, 1);
          check("out_valid_after", m_out_valid, 0);
          done = 1;
        end else begin
          drive(1'b0, rand40(1'b0), 1'b0);
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("job_timeout", 0, 1);
  endtask

  localparam logic [ND*DB-1:0] ALL1 = {ND{5'h01}};
  localparam logic [ND*DB-1:0] ALL2 = {ND{5'h02}};
  localparam logic [ND*DB-1:0] ALLF = {ND{5'h1F}};
  localparam logic [ND*DB-1:0] ZPAT = {5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2};

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_digits = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_digits = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_lut_en", a_lut_en, 0);
    check("rst_lut_sel", a_lut_sel, 0);
    check("rst_lut_digit", a_lut_digit, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_sum", a_out_sum, 0);
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready_a", a_in_ready, 1);
    check("release_in_ready_b", b_in_ready, 1);

    run_job(ALL1, 0, 1'b0);
    run_job(ALLF, 0, 1'b1);
    run_job(ZPAT, 0, 1'b0);
    run_job(rand40(1'b1), 5, 1'b0);
    run_job(rand40(1'b0), 0, 1'b0);

    // Reset in cycle 4 of a job aborts it; returning data must be dropped
    @(negedge clk);
    drive(1'b1, ALL1, 1'b1);
    @(negedge clk);
    drive(1'b0, rand40(1'b0), 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_lut_en", a_lut_en, 0);
    check("mid_rst_lut_sel", a_lut_sel, 0);
    check("mid_rst_lut_digit", a_lut_digit, 0);
    check("mid_rst_out_valid", a_out_valid, 0);
    check("mid_rst_out_sum", a_out_sum, 0);
    check("mid_rst_in_ready", a_in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_sum", a_out_sum, 0);
    check("post_rst_in_ready", a_in_ready, 1);
    run_job(ALL1, 0, 1'b0);

    for (int j = 0; j < 6; j++) run_job(rand40(1'b1), $urandom_range(0, 3), 1'b0);

    use_b = 1'b1;
    run_job(ALL2, 0, 1'b0);
    run_job(rand40(1'b1), 2, 1'b0);
    run_job(ZPAT, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xpb_reduce_seq.md
# xpb_reduce_seq

Sequencer that walks the upper digits of a wide product through the shared xpb precomputed-constant tables (x·2^k mod N per digit position). It adds the returned values into one reduction sum. It sits between the squaring multiplier's upper-digit output and the final modular-reduction adder. It time-multiplexes one registered table bank instead of instantiating one table per digit in parallel.

## Interface
- DIGIT_BITS, 5, table index width (one xpb digit)
- NUM_DIGITS, 8, digits per reduction job
- WORD_BITS, 1024, xpb table word width
- LUT_LATENCY, 1, cycles from lut_sel/lut_digit/lut_en to lut_data valid (≥1)
- ACC_BITS (localparam), WORD_BITS+$clog2(NUM_DIGITS), sum width
- clk  in  1  sole clock; one clock, reset synchronous active-high
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  sequencer idle, can accept
- in_digits  in  NUM_DIGITS*DIGIT_BITS  digit i = in_digits[i*DIGIT_BITS +: DIGIT_BITS]
- lut_en  out  1  table lookup issued this cycle
- lut_sel  out  $clog2(NUM_DIGITS)  digit position (selects table)
- lut_digit  out  DIGIT_BITS  table index
- lut_data  in  WORD_BITS  table word, valid LUT_LATENCY cycles after issue
- out_valid  out  1  sum available
- out_ready  in  1  consumer accepts
- out_sum  out  ACC_BITS  Σ table words

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_digits, clear acc, counter=0, go to RUN.
  - RUN: issue digit[counter] with lut_sel=counter, lut_en=1. Counter increments each cycle. After digit NUM_DIGITS-1 issues, go to DRAIN.
  - DRAIN: wait until the pipelined issue-valid shift register (depth LUT_LATENCY) is empty, then go to DONE.
  - DONE: out_valid=1, out_sum stable. On out_ready, go to IDLE.
- Accumulate:
  - acc <= acc + zero-extended lut_data in every cycle where the shifted issue-valid bit is 1.
  - Full-width add. ACC_BITS guarantees no overflow.
- in_digits is ignored outside the IDLE accept cycle.
- No new job overlaps an in-flight job. in_ready=0 in RUN, DRAIN and DONE.
- Reset values, forced at any edge with rst=1:
  - state=IDLE, acc=0, counter=0, issue-valid pipe cleared.
  - lut_en=0, lut_sel=0, lut_digit=0, out_valid=0, out_sum=0.
  - in_ready reads 0 while rst=1 and 1 from the first cycle after release.
- Reset mid-job aborts the job. lut_data still returning from before the reset is ignored because the pipe is cleared.
- Digit value 0 is issued normally (table returns 0) unless the configuration macro below is defined.

## Timing
- Accept edge = cycle 0.
- Digit i is issued in cycle 1+i.
- Its lut_data is added at the end of cycle 1+i+LUT_LATENCY.
- out_valid rises in cycle NUM_DIGITS+LUT_LATENCY+1 (10 with defaults).
- out_valid stays high and out_sum stays stable until out_ready is sampled high.
- With out_ready held high, out_valid lasts 1 cycle, and in_ready is 1 in the following cycle.
- Throughput: one job per NUM_DIGITS+LUT_LATENCY+2 cycles with no backpressure.
- lut_sel/lut_digit are registered outputs and hold their last value when lut_en=0.

## Configuration
- XPB_ZERO_SKIP_EN defined:
  - lut_en is driven 0 for digits equal to 0.
  - The issue-valid bit for those slots is 0, so no add occurs (saves table/adder toggling).
  - Cycle timing is unchanged; latency stays deterministic.
- XPB_ZERO_SKIP_EN undefined: lut_en=1 for every digit slot in RUN.
- The sum is identical in both builds.

## Structure
- Package xpb_seq_pkg: DIGIT_BITS default, state enum (IDLE, RUN, DRAIN, DONE).
- Sub-module xpb_seq_ctrl: FSM, digit counter, issue-valid shift register, handshake outputs.
- The top level holds the digit latch and the ACC_BITS accumulator.

## Test plan
- Bench table stub returns (lut_sel+1)*lut_digit with LUT_LATENCY=1. Use this stub in every scenario except the all-max one.
- All digits 5'h01, out_ready=1 → out_sum=36, out_valid high exactly in cycle 10, in_ready high in cycle 11.
- All digits 5'h1F with a stub returning 2^1024-1 → out_sum=2^1027-8 (ACC_BITS=1027, no wrap).
- Digits {0,3,0,0,0,0,0,2} (i=7..0) → out_sum = 2·1 + 3·7 = 23.
  - With XPB_ZERO_SKIP_EN, lut_en pulses only in cycles 1 and 7.
  - Without the macro, lut_en is high in cycles 1–8.
- out_ready held 0 for 5 cycles after out_valid → out_sum stable, in_ready=0 throughout. Accept on cycle 6, then a second job is accepted.
- rst pulsed in cycle 4 of a job → all outputs at reset values next cycle. The late lut_data is not added. A following job with all digits 5'h01 yields 36.
- LUT_LATENCY=3, all digits 5'h02 → out_sum=72, out_valid rises in cycle 12.
